// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the decode-to-execute stage: widths, control-bundle
// layout and the hard-wired zero register.
package id_ex_stage_pkg;

  localparam int DATA_W       = 32;
  localparam int REG_AW       = 5;
  localparam int CTRL_W       = 8;

  localparam int REGWRITE_BIT = 0;
  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 2;
  localparam int ALUSRC_BIT   = 3;
  localparam int ALUOP_LSB    = 4;
  localparam int ALUOP_W      = 4;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding selector: EX/MEM beats MEM/WB, which beats the
// operand stored in the ID/EX register. Register 0 never forwards.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_reg,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              exm_regwrite,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);

  logic exm_hit;
  logic wb_hit;

  always_comb begin
    exm_hit = exm_regwrite && (exm_rd != '0) && (exm_rd == src_reg);
    wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == src_reg);
    operand = stored_data;
    if (exm_hit) begin
      operand = exm_result;
    end else if (wb_hit) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection (one bubble, holds
// fetch/decode) and EX-side operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage #(
  parameter int DATA_W       = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW       = id_ex_stage_pkg::REG_AW,
  parameter int CTRL_W       = id_ex_stage_pkg::CTRL_W,
  parameter int MEMREAD_BIT  = id_ex_stage_pkg::MEMREAD_BIT,
  parameter int REGWRITE_BIT = id_ex_stage_pkg::REGWRITE_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              exm_regwrite,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [31:0]       stall_count
);

  // The two flag indices must address distinct bits of the bundle.
  if (MEMREAD_BIT >= CTRL_W || REGWRITE_BIT >= CTRL_W || MEMREAD_BIT == REGWRITE_BIT) begin : g_bad_ctrl_layout
    $error("id_ex_stage: invalid control-bundle bit layout");
  end

  // ex_valid qualifies every ex_* field; a bubble is ex_valid=0 with ex_ctrl=0
  // so no downstream write or memory access can fire from it.
  logic              ex_valid_q,   ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [REG_AW-1:0] rs_q,         rs_d;
  logic [REG_AW-1:0] rt_q,         rt_d;
  logic [DATA_W-1:0] rs_data_q,    rs_data_d;
  logic [DATA_W-1:0] rt_data_q,    rt_data_d;
  logic [31:0]       stall_count_q, stall_count_d;
  logic              hz;

  always_comb begin
    hz = id_valid && ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rd_q != '0) &&
         ((ex_rd_q == id_rs) || (ex_rd_q == id_rt));
    stall = hz && !flush;
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rd_d       = ex_rd_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_imm_d      = ex_imm_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    stall_count_d = stall_count_q;

    if (flush || stall) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rd_d    = '0;
    end else begin
      ex_valid_d = id_valid;
      ex_ctrl_d  = id_valid ? id_ctrl : '0;
      ex_rd_d    = id_rd;
      ex_imm_d   = id_imm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
    end

    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= '0;
      ex_ctrl_q     <= '0;
      ex_imm_q      <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_imm_q      <= ex_imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      stall_count_q <= stall_count_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_reg      (rs_q),
    .stored_data  (rs_data_q),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .operand      (ex_opa)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_reg      (rt_q),
    .stored_data  (rt_data_q),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .operand      (ex_opb)
  );

  assign ex_valid    = ex_valid_q;
  assign ex_rd       = ex_rd_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_imm      = ex_imm_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of decode/forwarding vectors checked through an
// expected queue, plus hand sequences for load-use, flush and async reset.
module tb_id_ex_stage;

  localparam int EXP_W = 1 + 5 + 8 + 32 + 32 + 32;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [7:0]  id_ctrl;
  logic        flush;
  logic        exm_regwrite;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_imm, ex_opa, ex_opb;
  logic [31:0] stall_count;

  int total;
  int bad;
  logic [EXP_W-1:0] exp_q[$];

  id_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_imm       (id_imm),
    .id_ctrl      (id_ctrl),
    .flush        (flush),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_ctrl      (ex_ctrl),
    .ex_imm       (ex_imm),
    .ex_opa       (ex_opa),
    .ex_opb       (ex_opb),
    .stall_count  (stall_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs;
    logic [31:0] rs_data;
    logic [4:0]  rt;
    logic [31:0] rt_data;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        x_we;
    logic [4:0]  x_rd;
    logic [31:0] x_res;
    logic        w_we;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [7:0]  e_ctrl;
    logic [31:0] e_imm;
    logic [31:0] e_opa;
    logic [31:0] e_opb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [7:0] ctrl);
    id_valid   = v;
    id_rs      = rs;
    id_rs_data = rsd;
    id_rt      = rt;
    id_rt_data = rtd;
    id_rd      = rd;
    id_imm     = imm;
    id_ctrl    = ctrl;
  endtask

  task automatic set_fwd(input logic xwe, input logic [4:0] xrd, input logic [31:0] xres,
                         input logic wwe, input logic [4:0] wrd, input logic [31:0] wdat);
    exm_regwrite = xwe;
    exm_rd       = xrd;
    exm_result   = xres;
    wb_regwrite  = wwe;
    wb_rd        = wrd;
    wb_data      = wdat;
  endtask

  function automatic logic [EXP_W-1:0] actual_bundle();
    return {ex_valid, ex_rd, ex_ctrl, ex_imm, ex_opa, ex_opb};
  endfunction

  // Puts a load (MemRead|RegWrite) with destination rd into the EX slot.
  task automatic issue_load(input logic [4:0] rd);
    @(negedge clk);
    flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, rd, 32'h4, 8'h03);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] cnt0;
  logic [EXP_W-1:0] exp_v;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    drive_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 8'h00);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    //            v  rs   rs_data        rt   rt_data        rd    imm            ctrl   xwe xrd  xres           wwe wrd  wdata          e_v e_rd  e_ctrl e_imm         e_opa          e_opb
    vecs[0] = '{1, 5'd3,  32'h11,       5'd4, 32'h22,       5'd8,  32'h10,        8'h01, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd8,  8'h01, 32'h10,        32'h11,        32'h22};
    vecs[1] = '{1, 5'd5,  32'h55,       5'd6, 32'h66,       5'd9,  32'hFFFF_FFF0, 8'h0D, 1, 5'd5, 32'hAA,       1, 5'd5, 32'hBB,       1, 5'd9,  8'h0D, 32'hFFFF_FFF0, 32'hAA,        32'h66};
    vecs[2] = '{1, 5'd1,  32'h1,        5'd2, 32'h2,        5'd10, 32'h7,         8'h81, 1, 5'd3, 32'hCC,       1, 5'd2, 32'hDD,       1, 5'd10, 8'h81, 32'h7,         32'h1,         32'hDD};
    vecs[3] = '{1, 5'd0,  32'h123,      5'd0, 32'h456,      5'd11, 32'h0,         8'h01, 1, 5'd0, 32'hEE,       1, 5'd0, 32'hFF,       1, 5'd11, 8'h01, 32'h0,         32'h123,       32'h456};
    vecs[4] = '{1, 5'd7,  32'h70,       5'd7, 32'h71,       5'd12, 32'h8,         8'h05, 0, 5'd7, 32'h99,       1, 5'd7, 32'h77,       1, 5'd12, 8'h05, 32'h8,         32'h77,        32'h77};
    vecs[5] = '{0, 5'd3,  32'h31,       5'd4, 32'h41,       5'd12, 32'h5,         8'hF1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd12, 8'h00, 32'h5,         32'h31,        32'h41};
    vecs[6] = '{1, 5'd10, 32'hA,        5'd9, 32'h9,        5'd13, 32'h1,         8'h09, 1, 5'd9, 32'h1234,     1, 5'd9, 32'h5678,     1, 5'd13, 8'h09, 32'h1,         32'hA,         32'h1234};
    vecs[7] = '{1, 5'd11, 32'hB,        5'd12, 32'hC,       5'd31, 32'h8000_0000, 8'h31, 1, 5'd11, 32'hDEAD,    1, 5'd12, 32'hBEEF,    1, 5'd31, 8'h31, 32'h8000_0000, 32'hDEAD,      32'hBEEF};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {88'h0, actual_bundle()}, 128'h0);
    chk("reset_stall", {127'h0, stall}, 128'h0);
    chk("reset_count", {96'h0, stall_count}, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    // table: decode captured on the edge, forwarding applied afterwards
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drive_id(vecs[i].valid, vecs[i].rs, vecs[i].rs_data, vecs[i].rt, vecs[i].rt_data,
               vecs[i].rd, vecs[i].imm, vecs[i].ctrl);
      #1;
      chk($sformatf("vec%0d_stall", i), {127'h0, stall}, 128'h0);
      exp_q.push_back({vecs[i].e_valid, vecs[i].e_rd, vecs[i].e_ctrl, vecs[i].e_imm,
                       vecs[i].e_opa, vecs[i].e_opb});
      @(posedge clk);
      #1;
      set_fwd(vecs[i].x_we, vecs[i].x_rd, vecs[i].x_res, vecs[i].w_we, vecs[i].w_rd, vecs[i].w_data);
      #1;
      if (exp_q.size() == 0) begin
        chk($sformatf("vec%0d_queue", i), 128'h0, 128'h1);
      end else begin
        exp_v = exp_q.pop_front();
        chk($sformatf("vec%0d_ex", i), {18'h0, actual_bundle()}, {18'h0, exp_v});
      end
    end
    chk("table_count", {96'h0, stall_count}, 128'h0);

    // load-use on rt: one bubble, then the consumer issues with the MEM/WB value
    cnt0 = stall_count;
    issue_load(5'd7);
    @(negedge clk);
    drive_id(1'b1, 5'd8, 32'h80, 5'd7, 32'h1, 5'd9, 32'h20, 8'h01);
    #1;
    chk("lu_stall", {127'h0, stall}, 128'h1);
    @(posedge clk);
    #1;
    chk("lu_bubble", {118'h0, ex_valid, ex_rd, ex_ctrl}, 128'h0);
    chk("lu_count", {96'h0, stall_count}, {96'h0, cnt0 + 32'd1});
    chk("lu_stall_drop", {127'h0, stall}, 128'h0);
    @(posedge clk);
    #1;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777);
    #1;
    chk("lu_issue", {18'h0, actual_bundle()}, {18'h0, 1'b1, 5'd9, 8'h01, 32'h20, 32'h80, 32'h7777});
    chk("lu_count_hold", {96'h0, stall_count}, {96'h0, cnt0 + 32'd1});

    // load to r0 never hazards
    cnt0 = stall_count;
    issue_load(5'd0);
    @(negedge clk);
    drive_id(1'b1, 5'd0, 32'h5, 5'd0, 32'h6, 5'd14, 32'h0, 8'h01);
    #1;
    chk("r0_stall", {127'h0, stall}, 128'h0);
    @(posedge clk);
    #1;
    chk("r0_issue", {123'h0, ex_valid, ex_rd}, {123'h0, 1'b1, 5'd14});
    chk("r0_count", {96'h0, stall_count}, {96'h0, cnt0});

    // flush beats the hazard
    cnt0 = stall_count;
    issue_load(5'd7);
    @(negedge clk);
    drive_id(1'b1, 5'd7, 32'h5, 5'd3, 32'h6, 5'd15, 32'h0, 8'h01);
    flush = 1'b1;
    #1;
    chk("flush_stall", {127'h0, stall}, 128'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_bubble", {118'h0, ex_valid, ex_rd, ex_ctrl}, 128'h0);
    chk("flush_count", {96'h0, stall_count}, {96'h0, cnt0});

    // async reset in the middle of a stall
    issue_load(5'd7);
    @(negedge clk);
    drive_id(1'b1, 5'd7, 32'h5, 5'd3, 32'h6, 5'd16, 32'h9, 8'h01);
    #1;
    chk("rst_pre_stall", {127'h0, stall}, 128'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_outputs", {88'h0, actual_bundle()}, 128'h0);
    chk("rst_stall", {127'h0, stall}, 128'h0);
    chk("rst_count", {96'h0, stall_count}, 128'h0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_after_issue", {123'h0, ex_valid, ex_rd}, {123'h0, 1'b1, 5'd16});
    chk("rst_after_count", {96'h0, stall_count}, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the register file read ports.
- Captures both register-file read operands, the immediate, the register specifiers and the control bundle into the ID/EX register.
- Detects load-use hazards and inserts one bubble while holding the fetch and decode stages.
- Applies EX-stage operand forwarding from the EX/MEM and MEM/WB stages. The register file writes on the falling clock edge, so decode reads already see same-cycle writeback data and no decode-side bypass is needed.

Parameters:
- DATA_W, 32, operand and immediate width.
- REG_AW, 5, register specifier width.
- CTRL_W, 8, width of the control bundle carried to EX.
- MEMREAD_BIT, 1, index of the MemRead flag inside the control bundle.
- REGWRITE_BIT, 0, index of the RegWrite flag inside the control bundle.

Ports:
- clk  in  1  stage clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_AW each  source and destination specifiers.
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data (Read_Data1/Read_Data2).
- id_imm  in  DATA_W  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control bundle.
- flush  in  1  branch/jump kill of the decode slot.
- exm_regwrite  in  1  EX/MEM stage will write a register.
- exm_rd  in  REG_AW  EX/MEM destination.
- exm_result  in  DATA_W  EX/MEM ALU result.
- wb_regwrite  in  1  MEM/WB stage will write a register.
- wb_rd  in  REG_AW  MEM/WB destination.
- wb_data  in  DATA_W  MEM/WB writeback data.
- stall  out  1  hold PC and the IF/ID register this cycle.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_rd  out  REG_AW  registered destination.
- ex_ctrl  out  CTRL_W  registered control bundle; forced to 0 when a bubble is inserted.
- ex_imm  out  DATA_W  registered immediate.
- ex_opa, ex_opb  out  DATA_W each  forwarded operands for the ALU.
- stall_count  out  32  saturating count of load-use stall cycles.

Behaviour:
- Reset (asynchronous): all ID/EX registers are 0. ex_valid=0, ex_ctrl=0, ex_rd=0, ex_imm=0. Stored operands are 0, so ex_opa/ex_opb read 0 when no forward hits. stall_count=0.
- Hazard (combinational):
  - hz = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
  - stall = hz & ~flush.
- Posedge update, priority order:
  1. flush=1: load a bubble (ex_valid=0, ex_ctrl=0, ex_rd=0). Other fields are don't-care but are held.
  2. stall=1: load a bubble. The decode inputs stay held upstream and are captured on the next cycle.
  3. Otherwise: capture all id_* fields; ex_valid=id_valid. When id_valid=0, ex_ctrl is forced to 0.
- Latency: one cycle from the decode inputs to the ex_* outputs. A load-use hazard adds exactly one bubble cycle, because the load then sits in MEM/WB and is covered by forwarding.
- Forwarding (combinational on the outputs, per operand; rs_q/rt_q are the stored specifiers):
  - If exm_regwrite & exm_rd!=0 & exm_rd==rs_q, use exm_result.
  - Else if wb_regwrite & wb_rd!=0 & wb_rd==rs_q, use wb_data.
  - Else use the stored operand.
  - ex_opb is built identically using rt_q. EX/MEM always takes priority over MEM/WB.
- Register 0 never hazards and never forwards.
- stall_count increments on every cycle with stall=1 and saturates at 32'hFFFFFFFF without wrapping.
- flush together with hz: flush wins, stall=0, the counter does not increment.
- Reset asserted mid-stall: the bubble is discarded, stall falls as soon as ex_valid clears, and the counter clears.

Decomposition:
- Shared package holds: the control-bundle bit indices (REGWRITE_BIT, MEMREAD_BIT, MEMWRITE_BIT, ALUSRC_BIT, ALUOP field), REG_AW, DATA_W, and the ZERO_REG constant.
- One sub-module, fwd_mux: the single-operand forwarding selector, instantiated twice (ex_opa, ex_opb).
- The hazard detector stays inline in id_ex_stage.

Test Plan:
- Reset, then id_valid=1, id_rs=3 with data 0x11, id_rt=4 with data 0x22, imm=0x10, no forwarding -> one cycle later ex_valid=1, ex_opa=0x11, ex_opb=0x22, ex_imm=0x10.
- ALU→ALU: ex holds rs_q=5, exm_regwrite=1, exm_rd=5, exm_result=0xAA, and wb_rd=5 with wb_data=0xBB -> ex_opa=0xAA (EX/MEM priority).
- Load-use: ex holds a load with ex_rd=7; decode has id_rt=7 -> stall=1 for exactly 1 cycle, next ex_valid=0 with ex_ctrl=0, stall_count=1, then the instruction issues with ex_opb=wb_data.
- Load-use where the load has ex_rd=0 -> stall=0, no bubble.
- flush=1 while a hazard is present -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
- Assert reset asynchronously mid-stall (between edges) -> all outputs 0 immediately, stall=0, stall_count=0.
